mem_responder: RTL
==================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The module SHALL have parameters (name, default, meaning): DEPTH_LOG2, 9, byte address bits of storage (512 bytes); WAIT_STATES, 2, extra cycles between request capture and completion (0..15).
REQ-002 The module SHALL have one clock and a synchronous, active-low reset: Clk  in  1  rising-edge clock; Clr  in  1  synchronous active-low reset.
REQ-003 Port: MFA  in  1  memory-function-activate request from datapath, level-held.
REQ-004 Port: OP  in  6  SPARC op3 access code.
REQ-005 Port: ADDR  in  32  byte address from MAR.
REQ-006 Port: DATA_IN  in  32  store data from MDR, right-justified.
REQ-007 Port: DATA_OUT  out  32  load data to MDR, right-justified.
REQ-008 Port: MFC  out  1  memory-function-complete.
REQ-009 Port: ERR  out  1  access rejected (misaligned or unsupported OP); valid while MFC=1.

Function
REQ-010 Supported OP: 0x00 LD word, 0x01 LDUB, 0x02 LDUH, 0x04 ST word, 0x05 STB, 0x06 STH, 0x08 instruction fetch (word load).
REQ-011 Storage SHALL be big-endian: byte at ADDR drives DATA bits 31:24 of a word access.
REQ-012 Only ADDR[DEPTH_LOG2-1:0] SHALL be used; higher bits ignored (wrap modulo 2^DEPTH_LOG2).
REQ-013 FSM states: IDLE, WAIT, DONE.
REQ-014 IDLE: MFA=1 at an edge captures OP, ADDR, DATA_IN, loads wait counter with WAIT_STATES, goes to WAIT.
REQ-015 WAIT: counter decrements each cycle; at zero the access executes and FSM goes to DONE with MFC=1.
REQ-016 Latency: MFA captured at edge N gives MFC=1 after edge N+1+WAIT_STATES.
REQ-017 Stores SHALL write memory only on the WAIT->DONE edge, byte lanes per size.
REQ-018 Unsigned loads zero-extend; DATA_OUT SHALL update only on WAIT->DONE and hold until the next completed load.
REQ-019 Misalignment (halfword ADDR[0]=1, word ADDR[1:0]!=0) or unsupported OP: no write, DATA_OUT unchanged, MFC=1 with ERR=1.
REQ-020 DONE: MFC held 1 while MFA=1; MFA=0 returns to IDLE with MFC=0, ERR=0 next edge.
REQ-021 MFA held high in DONE SHALL NOT start a new access; MFA must be low at least one cycle between accesses.
REQ-022 MFA dropping while in WAIT SHALL abort to IDLE: no write, no MFC.
REQ-023 Inputs changing after capture SHALL not affect the access in progress.

Reset
REQ-024 Clr=0 at an edge SHALL force IDLE, MFC=0, ERR=0, DATA_OUT=0, counter=0.
REQ-025 Reset mid-access SHALL abort without a memory write; memory contents SHALL NOT be cleared by reset.

Configuration
REQ-026 Macro MEM_SIGN_EXT_EN defined: OP 0x09 LDSB and 0x0A LDSH SHALL be supported, sign-extended to 32 bits, same alignment rules.
REQ-027 MEM_SIGN_EXT_EN undefined: 0x09 and 0x0A SHALL be unsupported (ERR=1).

Structure
REQ-028 Shared package mem_pkg SHALL hold op3 constants, access-size encoding, and FSM state typedef.
REQ-029 Storage SHALL be sub-module mem_byte_array (byte array named ram, 4 byte-lane write enables, combinational read), hierarchically preloadable by benches.

Verification
REQ-030 Preload ram[0..3]=9C,04,40,12; OP=0x08, ADDR=0, MFA=1 -> MFC=1 exactly 3 cycles after capture, DATA_OUT=32'h9C044012, ERR=0.
REQ-031 OP=0x05, ADDR=0x13, DATA_IN=32'h000000AB, then OP=0x01 same address -> DATA_OUT=32'h000000AB, neighbouring bytes unchanged.
REQ-032 OP=0x06, ADDR=0x21 -> MFC=1, ERR=1, memory and DATA_OUT unchanged; after MFA=0, MFC=0 and ERR=0 next edge.
REQ-033 ST 32'hDEADBEEF at ADDR=0x40, Clr=0 during WAIT -> IDLE, MFC=0; subsequent LD at 0x40 returns prior contents.
REQ-034 ram[0x50]=8'h80, OP=0x09 -> with MEM_SIGN_EXT_EN DATA_OUT=32'hFFFFFF80; without it ERR=1.
REQ-035 ADDR=0x204 with DEPTH_LOG2=9 accesses byte 0x004; MFA held high after MFC produces no second access.

Source files
------------

// File: rtl/mem_pkg.sv
// ============================================================================
// mem_pkg : op3 codes, access-size encoding, op decoder, FSM state type
// Config  : MEM_SIGN_EXT_EN enables LDSB/LDSH.  Rev 1.0
// ============================================================================
`default_nettype none

package mem_pkg;

  localparam logic [5:0] OP_LD     = 6'h00;
  localparam logic [5:0] OP_LDUB   = 6'h01;
  localparam logic [5:0] OP_LDUH   = 6'h02;
  localparam logic [5:0] OP_ST     = 6'h04;
  localparam logic [5:0] OP_STB    = 6'h05;
  localparam logic [5:0] OP_STH    = 6'h06;
  localparam logic [5:0] OP_IFETCH = 6'h08;
  localparam logic [5:0] OP_LDSB   = 6'h09;
  localparam logic [5:0] OP_LDSH   = 6'h0A;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic  valid;
    logic  store;
    logic  sign;
    size_e size;
  } op_dec_t;

  function automatic op_dec_t decode_op(input logic [5:0] op);
    op_dec_t d;
    d = '{valid: 1'b1, store: 1'b0, sign: 1'b0, size: SZ_WORD};
    case (op)
      OP_LD, OP_IFETCH: d.size = SZ_WORD;
      OP_LDUB:          d.size = SZ_BYTE;
      OP_LDUH:          d.size = SZ_HALF;
      OP_ST:            d.store = 1'b1;
      OP_STB:           begin d.store = 1'b1; d.size = SZ_BYTE; end
      OP_STH:           begin d.store = 1'b1; d.size = SZ_HALF; end
`ifdef MEM_SIGN_EXT_EN
      OP_LDSB:          begin d.sign = 1'b1; d.size = SZ_BYTE; end
      OP_LDSH:          begin d.sign = 1'b1; d.size = SZ_HALF; end
`else
      OP_LDSB, OP_LDSH: d.valid = 1'b0;
`endif
      default:          d.valid = 1'b0;
    endcase
    return d;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_byte_array.sv
// ============================================================================
// mem_byte_array : big-endian byte store, 4 lane write enables, async read
// Rev 1.0
// ============================================================================
`default_nettype none

module mem_byte_array #(
  parameter int DEPTH_LOG2 = 9
) (
  input  logic                  clk,
  input  logic [DEPTH_LOG2-3:0] i_word_addr,
  input  logic [3:0]            i_we,
  input  logic [31:0]           i_wdata,
  output logic [31:0]           o_rdata
);

  logic [7:0] ram [0:(2**DEPTH_LOG2)-1];

  // Lane 3 (i_we[3], bits 31:24) is the lowest byte address of the word
  always_ff @(posedge clk) begin
    for (int l = 0; l < 4; l++) begin
      if (i_we[3-l]) begin
        ram[{i_word_addr, l[1:0]}] <= i_wdata[31-8*l -: 8];
      end
    end
  end

  assign o_rdata = {ram[{i_word_addr, 2'd0}], ram[{i_word_addr, 2'd1}],
                    ram[{i_word_addr, 2'd2}], ram[{i_word_addr, 2'd3}]};

endmodule

`default_nettype wire

// File: rtl/mem_responder.sv
// ============================================================================
// mem_responder : MFA/MFC handshake memory with wait states and size decode
// Config : MEM_SIGN_EXT_EN adds sign-extending loads.  Rev 1.0
// ============================================================================
`default_nettype none

module mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_LOG2  = 9,
  parameter int WAIT_STATES = 2
) (
  input  logic        Clk,
  input  logic        Clr,
  input  logic        MFA,
  input  logic [5:0]  OP,
  input  logic [31:0] ADDR,
  input  logic [31:0] DATA_IN,
  output logic [31:0] DATA_OUT,
  output logic        MFC,
  output logic        ERR
);

  state_e                r_state;
  state_e                w_next;
  logic                  w_exec;
  logic [3:0]            r_cnt;
  logic [5:0]            r_op;
  logic [DEPTH_LOG2-1:0] r_addr;
  logic [31:0]           r_wdata;
  logic [31:0]           r_rdata;
  logic                  r_err;

  op_dec_t               w_dec;
  logic [1:0]            w_off;
  logic                  w_ok;
  logic [3:0]            w_we;
  logic [31:0]           w_wdata;
  logic [31:0]           w_rdata;
  logic [31:0]           w_load;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic                  w_unused_addr;

  assign w_unused_addr = ^ADDR[31:DEPTH_LOG2];

  always_ff @(posedge Clk) begin
    if (!Clr) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_exec = 1'b0;
    case (r_state)
      ST_IDLE: if (MFA) w_next = ST_WAIT;
      ST_WAIT: begin
        if (!MFA) begin
          w_next = ST_IDLE;
        end else if (r_cnt == 4'd0) begin
          w_next = ST_DONE;
          w_exec = 1'b1;
        end
      end
      ST_DONE: if (!MFA) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  assign w_dec = decode_op(r_op);
  assign w_off = r_addr[1:0];
  assign w_ok  = w_dec.valid &&
                 !((w_dec.size == SZ_HALF && w_off[0]) ||
                   (w_dec.size == SZ_WORD && w_off != 2'd0));

  always_comb begin
    w_we    = 4'b0000;
    w_wdata = r_wdata;
    w_byte  = w_rdata[31:24];
    w_half  = w_off[1] ? w_rdata[15:0] : w_rdata[31:16];
    case (w_off)
      2'd0:    w_byte = w_rdata[31:24];
      2'd1:    w_byte = w_rdata[23:16];
      2'd2:    w_byte = w_rdata[15:8];
      default: w_byte = w_rdata[7:0];
    endcase
    case (w_dec.size)
      SZ_BYTE: begin
        w_we    = 4'b1000 >> w_off;
        w_wdata = {4{r_wdata[7:0]}};
        w_load  = {{24{w_dec.sign & w_byte[7]}}, w_byte};
      end
      SZ_HALF: begin
        w_we    = w_off[1] ? 4'b0011 : 4'b1100;
        w_wdata = {2{r_wdata[15:0]}};
        w_load  = {{16{w_dec.sign & w_half[15]}}, w_half};
      end
      default: begin
        w_we    = 4'b1111;
        w_load  = w_rdata;
      end
    endcase
    // Reset on the completion edge must suppress the write as well
    if (!(w_exec && Clr && w_ok && w_dec.store)) w_we = 4'b0000;
  end

  always_ff @(posedge Clk) begin
    if (!Clr) begin
      r_cnt   <= 4'd0;
      r_op    <= 6'd0;
      r_addr  <= '0;
      r_wdata <= 32'd0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (MFA) begin
            r_cnt   <= 4'(WAIT_STATES);
            r_op    <= OP;
            r_addr  <= ADDR[DEPTH_LOG2-1:0];
            r_wdata <= DATA_IN;
            r_err   <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
          if (w_exec) begin
            r_err <= !w_ok;
            if (w_ok && !w_dec.store) r_rdata <= w_load;
          end
        end
        ST_DONE: if (!MFA) r_err <= 1'b0;
        default: r_err <= 1'b0;
      endcase
    end
  end

  mem_byte_array #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_mem (
    .clk         (Clk),
    .i_word_addr (r_addr[DEPTH_LOG2-1:2]),
    .i_we        (w_we),
    .i_wdata     (w_wdata),
    .o_rdata     (w_rdata)
  );

  assign DATA_OUT = r_rdata;
  assign MFC      = (r_state == ST_DONE);
  assign ERR      = r_err;

endmodule

`default_nettype wire
